// File: rtl/hsl_rgb_pipe.sv
// hsl_rgb_pipe: 5-stage HSL/HSV to RGB converter with brightness scaling.
// Ports: in_* beat + tag (valid/ready), out_r/g/b/tag (valid/ready), busy.
module hsl_rgb_pipe #(
  parameter int DW    = 8,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_h,
  input  logic [DW-1:0]    in_s,
  input  logic [DW-1:0]    in_l,
  input  logic             in_mode,
  input  logic [DW-1:0]    in_bri,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_r,
  output logic [DW-1:0]    out_g,
  output logic [DW-1:0]    out_b,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam logic [DW-1:0] MAX = '1;

  typedef struct packed {
    logic             v;
    logic [2:0]       sec;
    logic [DW-1:0]    f;
    logic [DW-1:0]    cb;
    logic [DW-1:0]    s;
    logic [DW-1:0]    l;
    logic             md;
    logic [DW-1:0]    bri;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             v;
    logic [2:0]       sec;
    logic [DW-1:0]    f;
    logic [DW-1:0]    c;
    logic [DW-1:0]    l;
    logic             md;
    logic [DW-1:0]    bri;
    logic [TAG_W-1:0] tag;
  } s2_t;

  typedef struct packed {
    logic             v;
    logic [2:0]       sec;
    logic [DW-1:0]    c;
    logic [DW-1:0]    x;
    logic [DW-1:0]    m;
    logic [DW-1:0]    bri;
    logic [TAG_W-1:0] tag;
  } s3_t;

  typedef struct packed {
    logic             v;
    logic [DW-1:0]    r;
    logic [DW-1:0]    g;
    logic [DW-1:0]    b;
    logic [DW-1:0]    bri;
    logic [TAG_W-1:0] tag;
  } s4_t;

  typedef struct packed {
    logic             v;
    logic [DW-1:0]    r;
    logic [DW-1:0]    g;
    logic [DW-1:0]    b;
    logic [TAG_W-1:0] tag;
  } s5_t;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  s3_t s3_q, s3_d;
  s4_t s4_q, s4_d;
  s5_t s5_q, s5_d;

  logic          stall;
  logic [DW+2:0] h6;
  logic [DW:0]   l2;
  logic [DW:0]   ad;
  logic [2*DW-1:0] pc;
  logic [DW:0]   fm;
  logic [2*DW:0] px;
  logic [DW-1:0] rp, gp, bp;

  function automatic logic [DW-1:0] sat_add(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW] ? MAX : s[DW-1:0];
  endfunction

  // (ch*(bri+1))>>DW: bri=MAX passes ch through, bri=0 blanks it
  function automatic logic [DW-1:0] scale(
    input logic [DW-1:0] ch,
    input logic [DW-1:0] bri
  );
    logic [2*DW:0] p;
    p = (2*DW+1)'(ch) * ((2*DW+1)'(bri) + (2*DW+1)'(1));
    return DW'(p >> DW);
  endfunction

  assign stall     = s5_q.v & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = s5_q.v;
  assign out_r     = s5_q.r;
  assign out_g     = s5_q.g;
  assign out_b     = s5_q.b;
  assign out_tag   = s5_q.tag;
  assign busy      = s1_q.v | s2_q.v | s3_q.v | s4_q.v | s5_q.v;

  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    s3_d = s3_q;
    s4_d = s4_q;
    s5_d = s5_q;
    rp   = '0;
    gp   = '0;
    bp   = '0;

    h6 = (DW+3)'(in_h) * (DW+3)'(6);
    l2 = {in_l, 1'b0};
    ad = (l2 >= {1'b0, MAX}) ? l2 - {1'b0, MAX}
                             : {1'b0, MAX} - l2;

    pc = (2*DW)'(s1_q.cb) * (2*DW)'(s1_q.s);

    // odd sectors fall from C, so use the complement of f (may be 2^DW)
    fm = s2_q.sec[0] ? (DW+1)'(1 << DW) - {1'b0, s2_q.f}
                     : {1'b0, s2_q.f};
    px = (2*DW+1)'(s2_q.c) * (2*DW+1)'(fm);

    case (s3_q.sec)
      3'd0:    begin rp = s3_q.c; gp = s3_q.x; end
      3'd1:    begin rp = s3_q.x; gp = s3_q.c; end
      3'd2:    begin gp = s3_q.c; bp = s3_q.x; end
      3'd3:    begin gp = s3_q.x; bp = s3_q.c; end
      3'd4:    begin rp = s3_q.x; bp = s3_q.c; end
      3'd5:    begin rp = s3_q.c; bp = s3_q.x; end
      default: ;
    endcase

    if (!stall) begin
      s1_d.v   = in_valid;
      s1_d.sec = h6[DW+2:DW];
      s1_d.f   = h6[DW-1:0];
      s1_d.cb  = in_mode ? in_l : MAX - DW'(ad);
      s1_d.s   = in_s;
      s1_d.l   = in_l;
      s1_d.md  = in_mode;
      s1_d.bri = in_bri;
      s1_d.tag = in_tag;

      s2_d.v   = s1_q.v;
      s2_d.sec = s1_q.sec;
      s2_d.f   = s1_q.f;
      s2_d.c   = DW'(pc >> DW);
      s2_d.l   = s1_q.l;
      s2_d.md  = s1_q.md;
      s2_d.bri = s1_q.bri;
      s2_d.tag = s1_q.tag;

      s3_d.v   = s2_q.v;
      s3_d.sec = s2_q.sec;
      s3_d.c   = s2_q.c;
      s3_d.x   = DW'(px >> DW);
      s3_d.m   = s2_q.md ? s2_q.l - s2_q.c
                         : s2_q.l - (s2_q.c >> 1);
      s3_d.bri = s2_q.bri;
      s3_d.tag = s2_q.tag;

      s4_d.v   = s3_q.v;
      s4_d.r   = sat_add(rp, s3_q.m);
      s4_d.g   = sat_add(gp, s3_q.m);
      s4_d.b   = sat_add(bp, s3_q.m);
      s4_d.bri = s3_q.bri;
      s4_d.tag = s3_q.tag;

      s5_d.v   = s4_q.v;
      s5_d.r   = scale(s4_q.r, s4_q.bri);
      s5_d.g   = scale(s4_q.g, s4_q.bri);
      s5_d.b   = scale(s4_q.b, s4_q.bri);
      s5_d.tag = s4_q.tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      s4_q <= '0;
      s5_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      s4_q <= s4_d;
      s5_q <= s5_d;
    end
  end

endmodule
